// File: rtl/fetch_pkg.sv
// fetch_pkg: entry layout and default depth shared by fetch, queue and decode
package fetch_pkg;
  localparam int FETCH_Q_DEPTH = 8;
  localparam int ENTRY_W       = 128;
  localparam int PC0_LO        = 0;
  localparam int PC0_HI        = 31;
  localparam int INSTR0_LO     = 32;
  localparam int INSTR0_HI     = 63;
  localparam int PC1_LO        = 64;
  localparam int PC1_HI        = 95;
  localparam int INSTR1_LO     = 96;
  localparam int INSTR1_HI     = 127;
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH x 128 storage, one synchronous write, two async reads
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  output logic [ENTRY_W-1:0]       rdata0_o,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [ENTRY_W-1:0]       rdata1_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  // store accepted pairs verbatim; contents need no reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: two-wide instruction pair queue between fetch and decode
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH    = FETCH_Q_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_fifo,
  input  logic [ENTRY_W-1:0]       fetch_instr_pc,
  input  logic                     flush,
  input  logic [1:0]               take,
  output logic [1:0]               out_valid,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_pc1,
  output logic                     stop_fetch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               half_q, half_d;
  logic [CW-1:0]      count_q, count_d;
  logic               stop_q, stop_d, ovf_q, ovf_d;
  logic [ENTRY_W-1:0] head, nxt;
  logic [1:0]         nvalid, take_sat, take_eff, pos;
  logic               full, freed, push, drop;
  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .we_i     (push),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (fetch_instr_pc),
    .raddr0_i (rd_ptr_q),
    .rdata0_o (head),
    .raddr1_i (rd_ptr_q + PW'(1)),
    .rdata1_o (nxt)
  );
  // consumption: valid slots, effective take and whether the head entry is freed
  always_comb begin
    nvalid   = count_q == '0 ? 2'd0 : (!half_q || count_q >= CW'(2)) ? 2'd2 : 2'd1;
    take_sat = take == 2'd3 ? 2'd2 : take;
    take_eff = take_sat > nvalid ? nvalid : take_sat;
    pos      = {1'b0, half_q} + take_eff;
    freed    = pos[1];
    full     = count_q == CW'(DEPTH);
    push     = write_fifo && !flush && (!full || freed);
    drop     = write_fifo && !flush && full && !freed;
  end
  // next state: flush clears occupancy but leaves the sticky overflow alone
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(freed);
    half_d   = pos[0];
    count_d  = count_q + CW'(push) - CW'(freed);
    ovf_d    = ovf_q || drop;
    stop_d   = count_d >= CW'(AF_LEVEL);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      half_d   = 1'b0;
      count_d  = '0;
      stop_d   = 1'b0;
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      half_q   <= 1'b0;
      count_q  <= '0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      half_q   <= half_d;
      count_q  <= count_d;
      stop_q   <= stop_d;
      ovf_q    <= ovf_d;
    end
  end
  // output slots from registered state only; invalid slots read as zero
  always_comb begin
    out_valid  = nvalid == 2'd2 ? 2'b11 : nvalid == 2'd1 ? 2'b01 : 2'b00;
    out_instr0 = nvalid == 2'd0 ? 32'd0 : half_q ? head[INSTR1_HI:INSTR1_LO] : head[INSTR0_HI:INSTR0_LO];
    out_pc0    = nvalid == 2'd0 ? 32'd0 : half_q ? head[PC1_HI:PC1_LO] : head[PC0_HI:PC0_LO];
    out_instr1 = nvalid != 2'd2 ? 32'd0 : half_q ? nxt[INSTR0_HI:INSTR0_LO] : head[INSTR1_HI:INSTR1_LO];
    out_pc1    = nvalid != 2'd2 ? 32'd0 : half_q ? nxt[PC0_HI:PC0_LO] : head[PC1_HI:PC1_LO];
  end
  assign stop_fetch = stop_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of pair entries (power of two, at least 4).
REQ-002 The block SHALL have parameter AF_LEVEL, default DEPTH-2, giving the occupancy at which stop_fetch asserts.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk input 1 (rising edge), rst_n input 1 (async active-low reset).
REQ-004 Port write_fifo input 1: push one pair entry this cycle.
REQ-005 Port fetch_instr_pc input 128: {instr1[127:96], pc1[95:64], instr0[63:32], pc0[31:0]}; instr0/pc0 is older in program order.
REQ-006 Port flush input 1: jump redirect; discard all queued and incoming instructions.
REQ-007 Port take input 2: number of instructions decode consumes this cycle (0, 1, 2; 3 treated as 2).
REQ-008 Port out_valid output 2: bit0 means slot0 valid; bit1 means slot1 valid (bit1 never set without bit0).
REQ-009 Ports out_instr0, out_pc0, out_instr1, out_pc1 output 32 each: slot0 is oldest, slot1 next in order.
REQ-010 Port stop_fetch output 1: backpressure to fetch, drives rready low upstream.
REQ-011 Port count output clog2(DEPTH)+1: occupied pair entries.
REQ-012 Port overflow output 1: sticky; a push was dropped because the queue was full.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH 128-bit entries with wrapping write and read pointers, plus a half flag meaning instr0 of the head entry is already consumed.
REQ-014 Output slots are combinational from registered state only, with no combinational path from inputs to outputs.
- half=0: slot0 = head.instr0, slot1 = head.instr1.
- half=1: slot0 = head.instr1, slot1 = (head+1).instr0 if count>=2, else invalid.
REQ-015 Invalid slots SHALL drive instr and pc as 0.
REQ-016 Push latency SHALL be 1: an entry pushed at edge N is visible on the outputs after edge N.
- A push into an empty queue does not bypass to the outputs in the same cycle.
REQ-017 Effective take SHALL be min(take, number of valid slots).
- The consumed instruction count advances the half flag.
- The read pointer advances by the number of entries fully consumed (0, 1 or 2 instructions crossing entry boundaries).
REQ-018 Simultaneous push and take in the same cycle SHALL both be honoured.
- count = count + push - entries_freed.
- A push to a full queue is honoured if the same cycle frees at least one entry.
REQ-019 A push when full with no entry freed SHALL be dropped, set overflow, and leave state unchanged.
REQ-020 flush SHALL take priority over push and take.
- Next cycle: pointers equal, half=0, count=0, out_valid=0.
- A push in the flush cycle is discarded.
- overflow is unaffected.
REQ-021 stop_fetch SHALL be registered, asserted when next count >= AF_LEVEL, and cleared when next count < AF_LEVEL or on flush.
- This leaves 2 entries of slack for in-flight beats.
REQ-022 Pointer and count arithmetic SHALL wrap modulo DEPTH; count saturates at DEPTH and is never negative.
REQ-023 Entries SHALL be stored verbatim; pc values are not recomputed.

Reset
REQ-024 On rst_n low, asynchronously: pointers=0, half=0, count=0, out_valid=0, all slot data outputs 0, stop_fetch=0, overflow=0.
REQ-025 Reset mid-operation SHALL discard all contents; the storage array need not be cleared.
REQ-026 First push is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package fetch_pkg SHALL hold the entry field slice constants (INSTR1/PC1/INSTR0/PC0 bit ranges) and the default FETCH_Q_DEPTH.
- The upstream fetch controller and decode use the same package.
REQ-028 Storage SHALL be one sub-module, fetch_queue_ram (DEPTH x 128, 1 write and 2 async read ports).
- Pointer, half, count and flag logic stay in instr_fetch_queue.

Verification
REQ-029 Push {I1=0x00200093, P1=0x4, I0=0x00100093, P0=0x0}, take=0 -> next cycle out_valid=2'b11, pc0=0x0, pc1=0x4, count=1.
REQ-030 Two entries (pcs 0,4,8,C), take=1 for three cycles -> slot0 pc sequence 0x0, 0x4, 0x8; after the third take, slot1 invalid with half=1 (slot0=0xC), count=1.
REQ-031 Fill to 6 entries with take=0 -> stop_fetch=1 after the 6th push edge; take=2 once -> stop_fetch=0 next cycle.
REQ-032 Full queue (8) plus push with take=0 -> entry dropped, overflow=1, count stays 8; full plus push with take=2 -> accepted, count stays 8.
REQ-033 5 entries, half=1, flush and push in the same cycle -> next cycle count=0, out_valid=0, stop_fetch=0; the pushed entry is never output.
REQ-034 Assert rst_n=0 mid-stream with 3 entries -> all outputs 0 immediately (asynchronously); after release the first push is visible one cycle later.
